// File: rtl/ldo_power_sequencer.sv
// Power sequencer for N_LDO LDOs: ordered power-up with pgood/settle per step, reverse power-down,
// fault latch on pgood loss or ramp timeout. Optional pgood synchronizer: LDO_SEQ_PGOOD_SYNC_EN.
module ldo_power_sequencer #(
  parameter int N_LDO = 3,
  parameter int CNT_W = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] dly_i,
  input  logic [CNT_W-1:0] timeout_i,
  input  logic [N_LDO-1:0] pgood_i,
  output logic [N_LDO-1:0] en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             fault_o,
  output logic [2:0]       fault_idx_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_RAMP, S_SETTLE, S_ON, S_DOWN, S_FAULT
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [N_LDO-1:0] en_nxt, pgood_s, pg_shift;
  logic [2:0]       fidx_nxt, lost_idx, hi_idx;
  logic             lost, settle_done, timed_out, pg_cur;

`ifdef LDO_SEQ_PGOOD_SYNC_EN
  logic [N_LDO-1:0] sync_q1, sync_q2;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= pgood_i;
      sync_q2 <= sync_q1;
    end
  end

  assign pgood_s = sync_q2;
`else
  assign pgood_s = pgood_i;
`endif

  assign cnt_inc     = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  assign settle_done = (dly_i == '0) || (cnt >= dly_i - CNT_W'(1));
  assign timed_out   = (timeout_i != '0) && (cnt == timeout_i - CNT_W'(1));
  assign pg_shift    = pgood_s >> idx;
  assign pg_cur      = pg_shift[0];

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt_inc;
    en_nxt    = en_o;
    fidx_nxt  = fault_idx_o;
    lost      = 1'b0;
    lost_idx  = '0;
    hi_idx    = '0;
    // Descending scan so the lowest failing enabled LDO wins.
    for (int i = N_LDO - 1; i >= 0; i--) begin
      if (en_o[i] && !pgood_s[i] && (state == S_ON || i < int'(idx))) begin
        lost     = 1'b1;
        lost_idx = 3'(i);
      end
    end
    for (int i = 0; i < N_LDO; i++) begin
      if (en_o[i]) hi_idx = 3'(i);
    end

    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (start_i) begin
          state_nxt = S_RAMP;
          idx_nxt   = '0;
          en_nxt    = N_LDO'(1);
        end
      end
      S_RAMP, S_SETTLE, S_ON: begin
        if (lost) begin
          state_nxt = S_FAULT;
          fidx_nxt  = lost_idx;
          en_nxt    = '0;
          cnt_nxt   = '0;
        end else if (state == S_RAMP && !pg_cur && timed_out) begin
          state_nxt = S_FAULT;
          fidx_nxt  = idx;
          en_nxt    = '0;
          cnt_nxt   = '0;
        end else if (stop_i) begin
          state_nxt = S_DOWN;
          en_nxt    = en_o & ~(N_LDO'(1) << hi_idx);
          cnt_nxt   = '0;
        end else if (state == S_RAMP && pg_cur) begin
          state_nxt = S_SETTLE;
          cnt_nxt   = '0;
        end else if (state == S_SETTLE && settle_done) begin
          cnt_nxt = '0;
          if (int'(idx) < N_LDO - 1) begin
            state_nxt = S_RAMP;
            idx_nxt   = idx + 3'd1;
            en_nxt    = en_o | (N_LDO'(1) << (idx + 3'd1));
          end else begin
            state_nxt = S_ON;
          end
        end
      end
      S_DOWN: begin
        // pgood is deliberately ignored while powering down.
        if (en_o == '0) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (settle_done) begin
          en_nxt  = en_o & ~(N_LDO'(1) << hi_idx);
          cnt_nxt = '0;
        end
      end
      S_FAULT: begin
        en_nxt  = '0;
        cnt_nxt = '0;
        if (clear_i) begin
          state_nxt = S_IDLE;
          fidx_nxt  = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        en_nxt    = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state       <= S_IDLE;
      idx         <= '0;
      cnt         <= '0;
      en_o        <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      fault_o     <= 1'b0;
      fault_idx_o <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cnt         <= cnt_nxt;
      en_o        <= en_nxt;
      busy_o      <= (state_nxt == S_RAMP) || (state_nxt == S_SETTLE) || (state_nxt == S_DOWN);
      done_o      <= (state_nxt == S_ON);
      fault_o     <= (state_nxt == S_FAULT);
      fault_idx_o <= fidx_nxt;
    end
  end

endmodule

// File: tb/tb_ldo_power_sequencer.sv
// Directed bench for ldo_power_sequencer (N_LDO=3, CNT_W=8, synchronizer disabled).
// Observed vector is {en, busy, done, fault, fault_idx}.
module tb_ldo_power_sequencer;
  localparam int N  = 3;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic [CW-1:0] dly = 8'd4, tmo = 8'd10;
  logic [N-1:0]  pgood = '0;
  logic [N-1:0]  en;
  logic          busy, done, fault;
  logic [2:0]    fidx;
  logic [8:0]    obs;
  int            checks = 0;
  int            errors = 0;

  ldo_power_sequencer #(.N_LDO(N), .CNT_W(CW)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start), .stop_i(stop), .clear_i(clear),
    .dly_i(dly), .timeout_i(tmo), .pgood_i(pgood), .en_o(en), .busy_o(busy),
    .done_o(done), .fault_o(fault), .fault_idx_o(fidx)
  );

  always #5 clk = ~clk;
  assign obs = {en, busy, done, fault, fidx};

  function automatic logic [8:0] st(input logic [2:0] e, input logic b, input logic d,
                                    input logic f, input logic [2:0] fi);
    return {e, b, d, f, fi};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] exp;
    rst_n = 1'b0;
    tick(2);
    exp = st(3'b000, 0, 0, 0, 3'd0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset: got %b exp %b", obs, exp); end
    rst_n = 1'b1;
    tick(1);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_release: got %b exp %b", obs, exp); end
  endtask

  // Full power-up; pgood[k] rises 3 cycles after en[k], settle of max(d,1) cycles follows.
  task automatic ramp_up(input string nm, input int d);
    logic [8:0] exp;
    logic [2:0] ep, en_next;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    exp = st(3'b001, 1, 0, 0, 3'd0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL %s_start: got %b exp %b", nm, obs, exp); end
    for (int k = 0; k < N; k++) begin
      ep      = 3'((1 << (k + 1)) - 1);
      en_next = 3'((1 << (k + 2)) - 1);
      tick(3);
      pgood[k] = 1'b1;
      tick(d < 1 ? 1 : d);
      exp = st(ep, 1, 0, 0, 3'd0);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL %s_settle%0d: got %b exp %b", nm, k, obs, exp); end
      tick(1);
      exp = (k < N - 1) ? st(en_next, 1, 0, 0, 3'd0) : st(3'b111, 0, 1, 0, 3'd0);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL %s_step%0d: got %b exp %b", nm, k, obs, exp); end
    end
  endtask

  task automatic do_clear(input string nm);
    logic [8:0] exp;
    pgood = '0;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    exp = st(3'b000, 0, 0, 0, 3'd0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL %s_clear: got %b exp %b", nm, obs, exp); end
  endtask

  task automatic test_power_up();
    logic [8:0] exp;
    pgood = '0;
    ramp_up("up", 4);
    start = 1'b1;
    clear = 1'b1;
    tick(2);
    start = 1'b0;
    clear = 1'b0;
    exp = st(3'b111, 0, 1, 0, 3'd0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL on_ignore: got %b exp %b", obs, exp); end
  endtask

  task automatic test_brown_out();
    logic [8:0] exp;
    pgood = 3'b011;
    tick(1);
    pgood = 3'b111;
    exp = st(3'b000, 0, 0, 1, 3'd2);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL brown_out: got %b exp %b", obs, exp); end
    start = 1'b1;
    stop  = 1'b1;
    tick(2);
    start = 1'b0;
    stop  = 1'b0;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL fault_hold: got %b exp %b", obs, exp); end
    do_clear("brown");
  endtask

  task automatic test_timeout();
    logic [8:0] exp;
    pgood = '0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    pgood = 3'b001;
    tick(5);
    exp = st(3'b011, 1, 0, 0, 3'd0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL tmo_en1: got %b exp %b", obs, exp); end
    tick(9);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL tmo_early: got %b exp %b", obs, exp); end
    tick(1);
    exp = st(3'b000, 0, 0, 1, 3'd1);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL tmo_fault: got %b exp %b", obs, exp); end
    do_clear("tmo");
  endtask

  task automatic test_ramp_loss();
    logic [8:0] exp;
    pgood = '0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    pgood = 3'b001;
    tick(7);
    pgood = 3'b000;
    tick(1);
    exp = st(3'b000, 0, 0, 1, 3'd0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL ramp_loss: got %b exp %b", obs, exp); end
    do_clear("loss");
  endtask

  task automatic test_power_down();
    logic [8:0] exp;
    pgood = '0;
    ramp_up("dn", 4);
    stop = 1'b1;
    tick(1);
    stop  = 1'b0;
    pgood = '0;
    exp = st(3'b011, 1, 0, 0, 3'd0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL down_entry: got %b exp %b", obs, exp); end
    tick(3);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL down_hold1: got %b exp %b", obs, exp); end
    tick(1);
    exp = st(3'b001, 1, 0, 0, 3'd0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL down_step1: got %b exp %b", obs, exp); end
    tick(3);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL down_hold2: got %b exp %b", obs, exp); end
    tick(1);
    exp = st(3'b000, 1, 0, 0, 3'd0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL down_step2: got %b exp %b", obs, exp); end
    tick(1);
    exp = st(3'b000, 0, 0, 0, 3'd0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL down_idle: got %b exp %b", obs, exp); end
  endtask

  task automatic test_stop_with_fault();
    logic [8:0] exp;
    pgood = '0;
    ramp_up("sf", 4);
    stop  = 1'b1;
    pgood = 3'b101;
    tick(1);
    stop = 1'b0;
    exp = st(3'b000, 0, 0, 1, 3'd1);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL stop_fault: got %b exp %b", obs, exp); end
    do_clear("sf");
  endtask

  task automatic test_reset_mid_ramp();
    logic [8:0] exp;
    pgood = '0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    pgood = 3'b001;
    tick(5);
    exp = st(3'b011, 1, 0, 0, 3'd0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rst_pre: got %b exp %b", obs, exp); end
    #2;
    rst_n = 1'b0;
    #1;
    exp = st(3'b000, 0, 0, 0, 3'd0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rst_async: got %b exp %b", obs, exp); end
    tick(1);
    pgood = '0;
    rst_n = 1'b1;
    tick(1);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rst_after: got %b exp %b", obs, exp); end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    exp = st(3'b001, 1, 0, 0, 3'd0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rst_restart: got %b exp %b", obs, exp); end
    tick(3);
    pgood = 3'b001;
    tick(5);
    exp = st(3'b011, 1, 0, 0, 3'd0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rst_idx0: got %b exp %b", obs, exp); end
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    pgood = '0;
  endtask

  task automatic test_dly_zero();
    logic [8:0] exp;
    dly   = '0;
    pgood = '0;
    ramp_up("d0", 0);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    exp = st(3'b011, 1, 0, 0, 3'd0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL d0_down1: got %b exp %b", obs, exp); end
    tick(1);
    exp = st(3'b001, 1, 0, 0, 3'd0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL d0_down2: got %b exp %b", obs, exp); end
    tick(1);
    exp = st(3'b000, 1, 0, 0, 3'd0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL d0_down3: got %b exp %b", obs, exp); end
    tick(1);
    exp = st(3'b000, 0, 0, 0, 3'd0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL d0_idle: got %b exp %b", obs, exp); end
    dly   = 8'd4;
    pgood = '0;
  endtask

  task automatic test_timeout_zero();
    logic [8:0] exp;
    tmo   = '0;
    pgood = '0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(300);
    exp = st(3'b001, 1, 0, 0, 3'd0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL tmo0_wait: got %b exp %b", obs, exp); end
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    exp = st(3'b000, 1, 0, 0, 3'd0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL tmo0_stop: got %b exp %b", obs, exp); end
    tick(1);
    exp = st(3'b000, 0, 0, 0, 3'd0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL tmo0_idle: got %b exp %b", obs, exp); end
    tmo = 8'd10;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_brown_out();
    test_timeout();
    test_ramp_loss();
    test_power_down();
    test_stop_with_fault();
    test_reset_mid_ramp();
    test_dly_zero();
    test_timeout_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
